// File: rtl/program_loader_if.sv
// Byte-in / word-out bus between a UART receiver, the program loader and the
// instruction memory plus MIPS core start control.
interface program_loader_if #(
    parameter int ADDR_W = 6
);
    logic [7:0]        rx_data;
    logic              rx_done;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              valid;
    logic              busy;
    logic [ADDR_W:0]   word_count;

    // master: UART/core side that feeds bytes and observes the loader
    modport master (
        output rx_data, rx_done,
        input  imem_we, imem_addr, imem_data, valid, busy, word_count
    );

    // slave: the loader itself
    modport slave (
        input  rx_data, rx_done,
        output imem_we, imem_addr, imem_data, valid, busy, word_count
    );
endinterface

// File: rtl/program_loader.sv
// Program loader: assembles big-endian 32-bit words from UART bytes, writes
// them into instruction memory, and releases the core once a halt word has
// been written or the memory is full.
//
// state | meaning
// IDLE  | waiting for the first byte of a load
// RECV  | collecting bytes of the current word
// WRITE | one-cycle instruction-memory write of the assembled word
// DONE  | load finished, core enabled, bytes ignored until reset
module program_loader #(
    parameter int          N_WORDS   = 64,
    parameter int          ADDR_W    = 6,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic           i_clk,
    input  logic           i_reset,
    program_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              word_end;
    logic [1:0]        byte_cnt;
    logic [31:0]       word_buf;
    logic [ADDR_W-1:0] word_addr;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [31:0]       imem_data_q;
    logic [ADDR_W:0]   word_count_q;

    // The word being written ends the load if it is the marker or fills memory.
    assign word_end = (imem_data_q == HALT_WORD) || (imem_addr_q == LAST_ADDR);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and byte-acceptance decode; a byte arriving during WRITE
    // starts the next word unless the load is ending.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.rx_done) begin
                    accept    = 1'b1;
                    state_nxt = RECV;
                end
            end
            RECV: begin
                if (bus.rx_done) begin
                    accept = 1'b1;
                    if (byte_cnt == 2'd3) begin
                        state_nxt = WRITE;
                    end
                end
            end
            WRITE: begin
                if (word_end) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = RECV;
                    accept    = bus.rx_done;
                end
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Byte assembly, write-port registers and word address/count bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            byte_cnt     <= '0;
            word_buf     <= '0;
            word_addr    <= '0;
            imem_addr_q  <= '0;
            imem_data_q  <= '0;
            word_count_q <= '0;
        end else begin
            if (accept) begin
                word_buf <= {word_buf[23:0], bus.rx_data};
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    imem_data_q <= {word_buf[23:0], bus.rx_data};
                    imem_addr_q <= word_addr;
                end
            end
            if (state == WRITE) begin
                word_count_q <= word_count_q + 1'b1;
                // Saturate at the top so the address never wraps within a load.
                if (imem_addr_q != LAST_ADDR) begin
                    word_addr <= word_addr + 1'b1;
                end
            end
        end
    end

    assign bus.imem_we    = (state == WRITE);
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_data  = imem_data_q;
    assign bus.valid      = (state == DONE);
    assign bus.busy       = (state == RECV) || (state == WRITE);
    assign bus.word_count = word_count_q;
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed load scenarios plus randomized loads,
// checked every cycle against a word-level reference model.
module tb_program_loader;
    localparam int          N_WORDS = 64;
    localparam int          ADDR_W  = 6;
    localparam logic [31:0] HALT    = 32'hFFFF_FFFF;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    program_loader_if #(.ADDR_W(ADDR_W)) bus();

    program_loader #(
        .N_WORDS  (N_WORDS),
        .ADDR_W   (ADDR_W),
        .HALT_WORD(HALT)
    ) dut (
        .i_clk  (clk),
        .i_reset(reset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state (word level)
    bit          m_started;
    bit          m_done;
    bit          m_we;
    int          m_nbytes;
    int          m_addr;
    int          m_count;
    logic [31:0] m_word;
    logic [31:0] m_last_data;
    int          m_last_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model across one clock edge with the given inputs.
    function automatic void model_edge(input bit rd, input logic [7:0] d, input bit rst);
        if (rst) begin
            m_started   = 0;
            m_done      = 0;
            m_we        = 0;
            m_nbytes    = 0;
            m_addr      = 0;
            m_count     = 0;
            m_word      = '0;
            m_last_data = '0;
            m_last_addr = 0;
        end else if (!m_done) begin
            if (m_we) begin
                m_count++;
                m_addr++;
                if (m_last_data == HALT || m_last_addr == N_WORDS - 1) m_done = 1;
            end
            m_we = 0;
            if (rd && !m_done) begin
                m_started = 1;
                m_word    = (m_word << 8) | 32'(d);
                m_nbytes++;
                if (m_nbytes == 4) begin
                    m_we        = 1;
                    m_last_addr = m_addr;
                    m_last_data = m_word;
                    m_nbytes    = 0;
                end
            end
        end
    endfunction

    task automatic step(input bit rd, input logic [7:0] d, input bit rst);
        bus.rx_done = rd;
        bus.rx_data = d;
        reset       = rst;
        @(posedge clk);
        #1;
        model_edge(rd, d, rst);
        chk("imem_we",    32'(bus.imem_we),    32'(m_we));
        chk("valid",      32'(bus.valid),      32'(m_done));
        chk("busy",       32'(bus.busy),       32'(m_started && !m_done));
        chk("word_count", 32'(bus.word_count), 32'(m_count));
        chk("imem_addr",  32'(bus.imem_addr),  32'(m_last_addr));
        chk("imem_data",  bus.imem_data,       m_last_data);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 8'h00, 0);
    endtask

    task automatic do_reset();
        step(0, 8'h00, 1);
        step(0, 8'h00, 1);
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        logic [31:0] v;
        v = w;
        for (int i = 0; i < 4; i++) begin
            step(1, v[31:24], 0);
            v = v << 8;
            repeat ($urandom_range(maxgap)) step(0, 8'h00, 0);
        end
    endtask

    initial begin
        logic [31:0] w;
        logic [7:0]  b;
        int          nw;
        bus.rx_done = 1'b0;
        bus.rx_data = 8'h00;

        // reset state
        do_reset();
        chk("rst_busy",  32'(bus.busy),       32'd0);
        chk("rst_count", 32'(bus.word_count), 32'd0);

        // single word, latency checked every cycle by the model
        send_word(32'h2008_0005, 0);
        idle(2);
        chk("w1_count", 32'(bus.word_count), 32'd1);
        chk("w1_data",  bus.imem_data,       32'h2008_0005);

        // halt terminates the load
        send_word(32'h2009_0003, 2);
        send_word(HALT, 1);
        idle(2);
        chk("halt_valid", 32'(bus.valid),      32'd1);
        chk("halt_count", 32'(bus.word_count), 32'd3);
        chk("halt_addr",  32'(bus.imem_addr),  32'd2);

        // strobes after completion are ignored
        for (int i = 0; i < 3; i++) send_word($urandom, 1);
        chk("done_valid", 32'(bus.valid),      32'd1);
        chk("done_count", 32'(bus.word_count), 32'd3);

        // reset mid-word, including a strobe in the reset cycle
        do_reset();
        step(1, 8'h11, 0);
        step(1, 8'h22, 0);
        step(1, 8'h33, 1);
        send_word(32'hAABB_CCDD, 0);
        idle(2);
        chk("midrst_data",  bus.imem_data,       32'hAABB_CCDD);
        chk("midrst_addr",  32'(bus.imem_addr),  32'd0);
        chk("midrst_count", 32'(bus.word_count), 32'd1);

        // back-to-back: byte 0 of the second word lands in the WRITE cycle
        do_reset();
        send_word(32'h0123_4567, 0);
        send_word(32'h89AB_CDEF, 0);
        idle(2);
        chk("b2b_data",  bus.imem_data,       32'h89AB_CDEF);
        chk("b2b_count", 32'(bus.word_count), 32'd2);

        // memory full ends the load, extra word is not written
        do_reset();
        for (int i = 0; i < N_WORDS; i++) begin
            w = $urandom;
            if (w == HALT) w = 32'h0;
            send_word(w, 1);
        end
        send_word(32'h1234_5678, 1);
        idle(2);
        chk("full_count", 32'(bus.word_count), 32'(N_WORDS));
        chk("full_addr",  32'(bus.imem_addr),  32'(N_WORDS - 1));
        chk("full_valid", 32'(bus.valid),      32'd1);

        // randomized loads with random gaps, halts and resets
        for (int l = 0; l < 20; l++) begin
            do_reset();
            nw = $urandom_range(1, 12);
            for (int i = 0; i < nw; i++) begin
                w = ($urandom_range(0, 5) == 0) ? HALT : $urandom;
                for (int k = 0; k < 4; k++) begin
                    b = w[31:24];
                    w = w << 8;
                    step(1, b, $urandom_range(0, 59) == 0);
                    repeat ($urandom_range(0, 2)) step($urandom_range(0, 9) == 0, 8'($urandom), 0);
                end
            end
            idle(3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
